// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter that sequences single read/write accesses into a shared register bank.
// Optional macro REG_ARB_LOCK_EN adds lock_i, letting a winner chain back-to-back accesses.
module reg_bank_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int N_REG  = 4,
    localparam int AW    = $clog2(N_REG)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ-1:0]        we_i,
    input  logic [N_REQ*AW-1:0]     addr_i,
    input  logic [N_REQ*DATA_W-1:0] wdata_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic [N_REQ-1:0]        ack_o,
    output logic [DATA_W-1:0]       rdata_o,
    output logic [N_REG*DATA_W-1:0] q_o
`ifdef REG_ARB_LOCK_EN
    ,
    input  logic [N_REQ-1:0]        lock_i
`endif
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IW-1:0]    LAST_RST = IW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] GNT_ONE  = N_REQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]     winIdx_q, winIdx_d;
    logic [IW-1:0]     last_q, last_d;
    logic              weLat_q, weLat_d;
    logic [AW-1:0]     addrLat_q, addrLat_d;
    logic [DATA_W-1:0] wdataLat_q, wdataLat_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] bank_q [N_REG];
    logic [DATA_W-1:0] bank_d [N_REG];

    logic [IW-1:0]     rrPick;
    logic [IW-1:0]     loadSel;
    logic              loadEn;
    logic              holdLock;

    // First requester found searching upward from the one after the last winner, with wrap.
    function automatic logic [IW-1:0] nextWinner(input logic [N_REQ-1:0] r,
                                                 input logic [IW-1:0]    last);
        logic [IW-1:0] pick;
        logic [IW-1:0] idxB;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx  = (int'(last) + k) % N_REQ;
            idxB = IW'(idx);
            if (!found && r[idxB]) begin
                pick  = idxB;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign rrPick = nextWinner(req_i, last_q);

`ifdef REG_ARB_LOCK_EN
    assign holdLock = lock_i[winIdx_q] & req_i[winIdx_q];
`else
    assign holdLock = 1'b0;
`endif

    // Next-state, bank update and input capture; captured inputs only change on a grant.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        winIdx_d   = winIdx_q;
        last_d     = last_q;
        weLat_d    = weLat_q;
        addrLat_d  = addrLat_q;
        wdataLat_d = wdataLat_q;
        rdata_d    = rdata_q;
        bank_d     = bank_q;
        loadEn     = 1'b0;
        loadSel    = rrPick;

        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    loadEn  = 1'b1;
                    loadSel = rrPick;
                    gnt_d   = GNT_ONE << rrPick;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (weLat_q) begin
                    bank_d[addrLat_q] = wdataLat_q;
                end else begin
                    rdata_d = bank_q[addrLat_q];
                end
                state_d = ACK;
            end
            ACK: begin
                if (holdLock) begin
                    loadEn  = 1'b1;
                    loadSel = winIdx_q;
                    state_d = ACCESS;
                end else begin
                    gnt_d   = '0;
                    last_d  = winIdx_q;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (loadEn) begin
            winIdx_d   = loadSel;
            weLat_d    = we_i[loadSel];
            addrLat_d  = addr_i[int'(loadSel)*AW +: AW];
            wdataLat_d = wdata_i[int'(loadSel)*DATA_W +: DATA_W];
        end
    end

    // Reset discards any transaction in flight along with the bank contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            winIdx_q   <= '0;
            last_q     <= LAST_RST;
            weLat_q    <= 1'b0;
            addrLat_q  <= '0;
            wdataLat_q <= '0;
            rdata_q    <= '0;
            for (int r = 0; r < N_REG; r++) begin
                bank_q[r] <= '0;
            end
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            winIdx_q   <= winIdx_d;
            last_q     <= last_d;
            weLat_q    <= weLat_d;
            addrLat_q  <= addrLat_d;
            wdataLat_q <= wdataLat_d;
            rdata_q    <= rdata_d;
            bank_q     <= bank_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign ack_o   = (state_q == ACK) ? gnt_q : '0;
    assign rdata_o = rdata_q;

    for (genvar r = 0; r < N_REG; r++) begin : gen_q
        assign q_o[r*DATA_W +: DATA_W] = bank_q[r];
    end

endmodule
